exu_arbiter: RTL and testbench
==============================

Name: exu_arbiter

Overview:
- Sequencer and arbiter that shares the single combinational execute unit between two requesters.
  - Requester 0: the core pipeline ALU op.
  - Requester 1: the LSU/CSR address and compare helper.
- Accepts one operation at a time over valid/ready, registers the operands and mode onto the EXU input bus, and captures the EXU result one cycle later.
- Returns the result on a single response channel tagged with the requester id.
- Sits between the IDU/LSU request side and the EXU instance.

Parameters:
- XLEN, 32, operand/result width
- MODEW, 11, EXU mode-vector width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_src1  in  XLEN  requester 0 operand 1
- req0_src2  in  XLEN  requester 0 operand 2
- req0_imm  in  XLEN  requester 0 immediate
- req0_mode  in  MODEW  requester 0 EXU mode vector
- req1_valid, req1_ready, req1_src1, req1_src2, req1_imm, req1_mode  same as requester 0, for requester 1
- exu_rdata1  out  XLEN  registered operand to EXU gpr_rdata1_in
- exu_rdata2  out  XLEN  registered operand to EXU gpr_rdata2_in
- exu_imm  out  XLEN  registered immediate to EXU
- exu_mode  out  MODEW  registered mode to EXU
- exu_data  in  XLEN  EXU combinational result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  XLEN  captured result
- rsp_id  out  1  requester that issued it
- rsp_err  out  1  mode was not a supported encoding

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; all outputs go to 0, including exu_mode = 0.
  - Round-robin pointer reset gives requester 0 priority.
  - Any in-flight operation is dropped silently.
- States:
  - IDLE:
    - reqX_ready = grant(X) is combinational; only one ready is high at a time.
    - Grant goes to the single valid requester. If both are valid, it goes to the one not granted last (round-robin). The pointer updates only on an accepted request.
    - On accept: latch src1/src2/imm/mode onto the exu_* registers, latch id and err, go to EXEC.
  - EXEC (1 cycle):
    - EXU inputs are stable; capture exu_data into rsp_data at the clock edge.
    - If err, capture 0 instead.
    - Go to RESP.
  - RESP:
    - rsp_valid = 1; rsp_data/rsp_id/rsp_err are held stable until rsp_valid & rsp_ready.
    - On that handshake: go to IDLE and clear exu_mode to 0. exu_rdata/imm may hold.
- Latency and throughput:
  - Request accepted at edge T gives rsp_valid at T+2 at the earliest.
  - At most one operation is in flight; req ready is low in EXEC and RESP. Max throughput is 1 op per 3 cycles.
- Supported mode[10:1] encodings: 0, 1, 2, 4, 16, 64, 128 (add, sub, ucmp, scmp, srl-style shift, xor, and). mode[0] is a free operand select.
  - Any other value: rsp_err = 1, rsp_data = 0, and exu_mode is still driven.
- A requester's valid dropping before grant is legal; no grant is issued to a non-valid requester.
- Request fields are sampled only on the accept edge; later changes have no effect.
- rsp_ready held high: the response completes in a single RESP cycle.
- Reset asserted in EXEC/RESP: the result is lost, and no rsp_valid is seen after release.

Decomposition:
- Shared package exu_pkg:
  - EXU mode-vector constants (MODE_ADD, MODE_SUB, MODE_UCMP, MODE_SCMP, MODE_SRL, MODE_XOR, MODE_AND, MODE_IMM bit)
  - MODEW/XLEN constants
  - State encoding localparams IDLE/EXEC/RESP
- One natural sub-module: rr_arb2, the 2-way round-robin grant with pointer register, reset to requester 0 priority.

Test Plan:
- Single add: req0 src1=5, src2=7, mode=0, rsp_ready=1 → req0_ready at T, exu_mode=0 at T+1, rsp_valid at T+2 with data=12, id=0, err=0.
- Contention: both valid continuously, req1 src1=10, imm=3, mode=11'b1_1 (sub imm), rsp_ready=1 → grants alternate 0,1,0,1; req1 responses data=7, id=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → data/id stable, both reqX_ready=0 throughout; release yields one handshake then IDLE.
- Unsupported mode: mode[10:1]=10'b00_0000_1000 → rsp_err=1, rsp_data=0.
- Signed compare: src1=0xFFFFFFFF, src2=1, mode[10:1]=4 → rsp_data=0x4. Same operands with mode[10:1]=2 → rsp_data=0x2.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 immediately. After release, rsp_valid stays 0 until a new request is accepted; first grant goes to req0 when both are valid.

Source files
------------

// File: rtl/exu_pkg.sv
// Shared constants, state encoding and request payload for the EXU arbiter.
package exu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MODEW = 11;

    localparam logic [MODEW-1:0] MODE_IMM  = 11'h001;
    localparam logic [MODEW-1:0] MODE_ADD  = 11'h000;
    localparam logic [MODEW-1:0] MODE_SUB  = 11'h002;
    localparam logic [MODEW-1:0] MODE_UCMP = 11'h004;
    localparam logic [MODEW-1:0] MODE_SCMP = 11'h008;
    localparam logic [MODEW-1:0] MODE_SRL  = 11'h020;
    localparam logic [MODEW-1:0] MODE_XOR  = 11'h080;
    localparam logic [MODEW-1:0] MODE_AND  = 11'h100;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_EXEC = EXEC,
        ST_RESP = RESP
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  src1;
        logic [XLEN-1:0]  src2;
        logic [XLEN-1:0]  imm;
        logic [MODEW-1:0] mode;
    } exu_req_t;

    // bit 0 is a free operand select, so only the upper bits select the operation
    function automatic logic mode_supported(input logic [MODEW-1:0] mode);
        logic [MODEW-2:0] op;
        op = mode[MODEW-1:1];
        return op inside {MODE_ADD[MODEW-1:1], MODE_SUB[MODEW-1:1], MODE_UCMP[MODEW-1:1],
                          MODE_SCMP[MODEW-1:1], MODE_SRL[MODEW-1:1], MODE_XOR[MODEW-1:1],
                          MODE_AND[MODEW-1:1]};
    endfunction

endpackage

// File: rtl/exu_arbiter_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c_o
);

    logic prio_q, prio_d;

    always_comb begin
        gnt_c_o = 2'b00;
        prio_d  = prio_q;
        if (en_i) begin
            if (req_i[prio_q]) begin
                gnt_c_o[prio_q] = 1'b1;
            end else if (req_i[~prio_q]) begin
                gnt_c_o[~prio_q] = 1'b1;
            end
            // every grant is an accept, so the pointer moves past the winner
            if (|gnt_c_o) begin
                prio_d = ~gnt_c_o[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/exu_arbiter.sv
// Shares one combinational EXU between two requesters: accept, execute, respond.
module exu_arbiter
    import exu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_src1,
    input  logic [XLEN-1:0]  req0_src2,
    input  logic [XLEN-1:0]  req0_imm,
    input  logic [MODEW-1:0] req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_src1,
    input  logic [XLEN-1:0]  req1_src2,
    input  logic [XLEN-1:0]  req1_imm,
    input  logic [MODEW-1:0] req1_mode,
    output logic [XLEN-1:0]  exu_rdata1,
    output logic [XLEN-1:0]  exu_rdata2,
    output logic [XLEN-1:0]  exu_imm,
    output logic [MODEW-1:0] exu_mode,
    input  logic [XLEN-1:0]  exu_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_id,
    output logic             rsp_err
);

    state_e          state_q, state_d;
    exu_req_t        exu_q, exu_d;
    exu_req_t        req0_s, req1_s;
    logic            id_q, id_d;
    logic            err_q, err_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]      gnt;

    assign req0_s = '{src1: req0_src1, src2: req0_src2, imm: req0_imm, mode: req0_mode};
    assign req1_s = '{src1: req1_src1, src2: req1_src2, imm: req1_imm, mode: req1_mode};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == ST_IDLE),
        .req_i   ({req1_valid, req0_valid}),
        .gnt_c_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        state_d     = state_q;
        exu_d       = exu_q;
        id_d        = id_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    exu_d   = gnt[1] ? req1_s : req0_s;
                    id_d    = gnt[1];
                    err_d   = !mode_supported(exu_d.mode);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // an unsupported mode still reaches the EXU, but its output is discarded
                rsp_data_d  = err_q ? '0 : exu_data;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    exu_d.mode  = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exu_q       <= '0;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            exu_q       <= exu_d;
            id_q        <= id_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign exu_rdata1 = exu_q.src1;
    assign exu_rdata2 = exu_q.src2;
    assign exu_imm    = exu_q.imm;
    assign exu_mode   = exu_q.mode;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = id_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_exu_arbiter.sv
// Bench for exu_arbiter: a behavioural EXU drives exu_data, scenarios are checked against a reference model.
module tb_exu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_src1, req0_src2, req0_imm, req1_src1, req1_src2, req1_imm;
    logic [10:0] req0_mode, req1_mode;
    logic [31:0] exu_rdata1, exu_rdata2, exu_imm, exu_data;
    logic [10:0] exu_mode;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] imm;
        logic [10:0] mode;
    } req_t;

    int n_chk = 0;
    int n_pass = 0;
    bit last_gid;

    bit          o_timeout, o_gid, o_both_rdy, o_exec_valid, o_valid, o_id, o_err;
    bit          o_stable, o_busy_rdy, o_post_valid;
    logic [10:0] o_exec_mode, o_post_mode;
    logic [31:0] o_exec_r1, o_data;

    always #5 clk = ~clk;

    exu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_imm(req0_imm), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_imm(req1_imm), .req1_mode(req1_mode),
        .exu_rdata1(exu_rdata1), .exu_rdata2(exu_rdata2), .exu_imm(exu_imm),
        .exu_mode(exu_mode), .exu_data(exu_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    // Compare results are a {lt, gt, eq} flag triple; unknown modes give a poison value.
    function automatic logic [31:0] exu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] imm, input logic [10:0] mode);
        logic [31:0] op2;
        op2 = mode[0] ? imm : b;
        case (mode[10:1])
            10'd0:   return a + op2;
            10'd1:   return a - op2;
            10'd2:   return {29'd0, a < op2, a > op2, a == op2};
            10'd4:   return {29'd0, $signed(a) < $signed(op2), $signed(a) > $signed(op2), a == op2};
            10'd16:  return a >> op2[4:0];
            10'd64:  return a ^ op2;
            10'd128: return a & op2;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb exu_data = exu_fn(exu_rdata1, exu_rdata2, exu_imm, exu_mode);

    function automatic bit exp_err(input logic [10:0] mode);
        logic [9:0] op;
        op = mode[10:1];
        return !(op inside {10'd0, 10'd1, 10'd2, 10'd4, 10'd16, 10'd64, 10'd128});
    endfunction

    function automatic logic [31:0] exp_data(input req_t r);
        return exp_err(r.mode) ? 32'd0 : exu_fn(r.s1, r.s2, r.imm, r.mode);
    endfunction

    function automatic bit exp_gid(input bit v0, input bit v1);
        return (v0 && v1) ? !last_gid : v1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        {req0_src1, req0_src2, req0_imm, req0_mode} = '0;
        {req1_src1, req1_src2, req1_imm, req1_mode} = '0;
        repeat (2) @(posedge clk);
        #1;
        last_gid = 1'b1;
    endtask

    // Drives one operation through accept/exec/resp and records what the DUT showed.
    task automatic issue(input bit v0, input bit v1, input req_t r0, input req_t r1,
                         input int hold, input bit keep);
        o_timeout = 0; o_stable = 1; o_busy_rdy = 0; o_both_rdy = 0;
        req0_valid = v0; req0_src1 = r0.s1; req0_src2 = r0.s2; req0_imm = r0.imm; req0_mode = r0.mode;
        req1_valid = v1; req1_src1 = r1.s1; req1_src2 = r1.s2; req1_imm = r1.imm; req1_mode = r1.mode;
        rsp_ready = (hold == 0);
        for (int t = 0; t <= 20; t++) begin
            #1;
            if (req0_ready || req1_ready) break;
            if (t == 20) begin
                o_timeout = 1;
                return;
            end
            @(posedge clk);
        end
        o_gid = req1_ready;
        o_both_rdy = req0_ready && req1_ready;
        @(posedge clk); #1;
        if (!keep) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            {req0_src1, req0_src2, req0_imm, req0_mode} = {$urandom, $urandom, $urandom, 11'($urandom)};
            {req1_src1, req1_src2, req1_imm, req1_mode} = {$urandom, $urandom, $urandom, 11'($urandom)};
        end
        #2;
        o_exec_mode = exu_mode; o_exec_r1 = exu_rdata1; o_exec_valid = rsp_valid;
        o_busy_rdy |= req0_ready | req1_ready;
        @(posedge clk); #1;
        o_valid = rsp_valid; o_data = rsp_data; o_id = rsp_id; o_err = rsp_err;
        o_busy_rdy |= req0_ready | req1_ready;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (k == hold - 1) rsp_ready = 1'b1;
            #1;
            o_stable &= (rsp_valid === 1'b1) && (rsp_data === o_data) && (rsp_id === o_id) && (rsp_err === o_err);
            o_busy_rdy |= req0_ready | req1_ready;
        end
        @(posedge clk); #1;
        o_post_valid = rsp_valid; o_post_mode = exu_mode;
        last_gid = exp_gid(v0, v1);
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rsp_valid); else n_pass++;
        n_chk++; if (rsp_data !== 32'd0) $display("FAIL rst_data: got %h want 0", rsp_data); else n_pass++;
        n_chk++; if ({rsp_id, rsp_err} !== 2'b00) $display("FAIL rst_id_err: got %b want 00", {rsp_id, rsp_err}); else n_pass++;
        n_chk++; if (exu_mode !== 11'd0) $display("FAIL rst_mode: got %h want 0", exu_mode); else n_pass++;
        n_chk++; if ({exu_rdata1, exu_rdata2, exu_imm} !== 96'd0) $display("FAIL rst_exu_bus: got %h want 0", {exu_rdata1, exu_rdata2, exu_imm}); else n_pass++;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        req_t r0, rz;
        r0 = '{s1: 32'd5, s2: 32'd7, imm: 32'd99, mode: 11'd0};
        rz = '{s1: 32'd0, s2: 32'd0, imm: 32'd0, mode: 11'd0};
        issue(1, 0, r0, rz, 0, 0);
        n_chk++; if (o_timeout !== 1'b0) $display("FAIL add_timeout: no grant within bound"); else n_pass++;
        n_chk++; if (o_gid !== 1'b0) $display("FAIL add_gid: got %b want 0", o_gid); else n_pass++;
        n_chk++; if (o_exec_mode !== 11'd0) $display("FAIL add_exec_mode: got %h want 0", o_exec_mode); else n_pass++;
        n_chk++; if (o_exec_r1 !== 32'd5) $display("FAIL add_exec_rdata1: got %h want 5", o_exec_r1); else n_pass++;
        n_chk++; if (o_exec_valid !== 1'b0) $display("FAIL add_early_valid: got %b want 0", o_exec_valid); else n_pass++;
        n_chk++; if (o_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", o_valid); else n_pass++;
        n_chk++; if (o_data !== 32'd12) $display("FAIL add_data: got %0d want 12", o_data); else n_pass++;
        n_chk++; if ({o_id, o_err} !== 2'b00) $display("FAIL add_id_err: got %b want 00", {o_id, o_err}); else n_pass++;
        n_chk++; if (o_post_valid !== 1'b0) $display("FAIL add_post_valid: got %b want 0", o_post_valid); else n_pass++;
    endtask

    task automatic test_contention();
        req_t r0, r1;
        bit want[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        rst_n = 1'b1;
        r0 = '{s1: $urandom, s2: $urandom, imm: $urandom, mode: 11'd0};
        r1 = '{s1: 32'd10, s2: $urandom, imm: 32'd3, mode: 11'b000_0000_0011};
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, r0, r1, 0, 1);
            n_chk++; if (o_timeout !== 1'b0 || o_gid !== want[i]) $display("FAIL cont_gid[%0d]: got %b (timeout %b) want %b", i, o_gid, o_timeout, want[i]); else n_pass++;
            n_chk++; if (o_both_rdy !== 1'b0 || o_busy_rdy !== 1'b0) $display("FAIL cont_ready[%0d]: both %b busy %b want 0 0", i, o_both_rdy, o_busy_rdy); else n_pass++;
            n_chk++; if (o_data !== (want[i] ? 32'd7 : r0.s1 + r0.s2) || o_id !== want[i]) $display("FAIL cont_rsp[%0d]: got %h id %b want %h id %b", i, o_data, o_id, want[i] ? 32'd7 : r0.s1 + r0.s2, want[i]); else n_pass++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        req_t r0, r1;
        r0 = '{s1: 32'h1234_5678, s2: 32'h0F0F_0F0F, imm: 32'd0, mode: 11'h080};
        r1 = '{s1: 32'h1111_0000, s2: 32'h0000_2222, imm: 32'd0, mode: 11'h100};
        issue(1, 1, r0, r1, 5, 0);
        n_chk++; if (o_timeout !== 1'b0 || o_data !== exp_data(o_gid ? r1 : r0)) $display("FAIL bp_data: got %h want %h", o_data, exp_data(o_gid ? r1 : r0)); else n_pass++;
        n_chk++; if (o_stable !== 1'b1) $display("FAIL bp_stable: response changed while stalled (got %b want 1)", o_stable); else n_pass++;
        n_chk++; if (o_busy_rdy !== 1'b0) $display("FAIL bp_ready: got %b want 0 while busy", o_busy_rdy); else n_pass++;
        n_chk++; if (o_post_valid !== 1'b0 || o_post_mode !== 11'd0) $display("FAIL bp_release: valid %b mode %h want 0 0", o_post_valid, o_post_mode); else n_pass++;
    endtask

    task automatic test_unsupported();
        req_t r0;
        r0 = '{s1: 32'd40, s2: 32'd2, imm: 32'd0, mode: {10'b00_0000_1000, 1'b0}};
        issue(0, 1, r0, r0, 0, 0);
        n_chk++; if (o_err !== 1'b1 || o_data !== 32'd0) $display("FAIL unsup_rsp: err %b data %h want 1 0", o_err, o_data); else n_pass++;
        n_chk++; if (o_exec_mode !== r0.mode || o_id !== 1'b1) $display("FAIL unsup_mode_id: mode %h id %b want %h 1", o_exec_mode, o_id, r0.mode); else n_pass++;
    endtask

    task automatic test_compare();
        req_t r;
        r = '{s1: 32'hFFFF_FFFF, s2: 32'd1, imm: 32'd0, mode: {10'd4, 1'b0}};
        issue(1, 0, r, r, 0, 0);
        n_chk++; if (o_data !== 32'h4 || o_err !== 1'b0) $display("FAIL scmp: got %h err %b want 4 0", o_data, o_err); else n_pass++;
        r.mode = {10'd2, 1'b0};
        issue(1, 0, r, r, 0, 0);
        n_chk++; if (o_data !== 32'h2 || o_err !== 1'b0) $display("FAIL ucmp: got %h err %b want 2 0", o_data, o_err); else n_pass++;
    endtask

    task automatic test_random();
        logic [9:0] ops[7] = '{10'd0, 10'd1, 10'd2, 10'd4, 10'd16, 10'd64, 10'd128};
        req_t r0, r1;
        bit v0, v1, g;
        int pat;
        for (int i = 0; i < 30; i++) begin
            r0 = '{s1: $urandom, s2: $urandom, imm: $urandom, mode: {ops[$urandom_range(0, 6)], 1'($urandom)}};
            r1 = '{s1: $urandom, s2: $urandom, imm: $urandom, mode: {ops[$urandom_range(0, 6)], 1'($urandom)}};
            if ($urandom_range(0, 7) == 0) r1.mode = 11'($urandom);
            pat = $urandom_range(1, 3);
            v0 = pat[0]; v1 = pat[1];
            g = exp_gid(v0, v1);
            issue(v0, v1, r0, r1, $urandom_range(0, 2), 0);
            n_chk++; if (o_timeout !== 1'b0 || o_gid !== g) $display("FAIL rnd_gid[%0d]: got %b (timeout %b) want %b", i, o_gid, o_timeout, g); else n_pass++;
            n_chk++; if (o_data !== exp_data(g ? r1 : r0)) $display("FAIL rnd_data[%0d]: got %h want %h", i, o_data, exp_data(g ? r1 : r0)); else n_pass++;
            n_chk++; if (o_err !== exp_err(g ? r1.mode : r0.mode) || o_id !== g) $display("FAIL rnd_err_id[%0d]: got %b %b want %b %b", i, o_err, o_id, exp_err(g ? r1.mode : r0.mode), g); else n_pass++;
            n_chk++; if (o_post_valid !== 1'b0 || o_stable !== 1'b1) $display("FAIL rnd_hs[%0d]: post %b stable %b want 0 1", i, o_post_valid, o_stable); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        req0_valid = 1'b1; req0_src1 = 32'd3; req0_src2 = 32'd4; req0_imm = 32'd0; req0_mode = 11'h100;
        req1_valid = 1'b0; rsp_ready = 1'b1;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            #1;
            seen = req0_ready;
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++; if (seen !== 1'b1) $display("FAIL mid_accept: got %b want 1", seen); else n_pass++;
        n_chk++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b000 || rsp_data !== 32'd0) $display("FAIL mid_rsp: got %b %h want 000 0", {rsp_valid, rsp_id, rsp_err}, rsp_data); else n_pass++;
        n_chk++; if (exu_mode !== 11'd0 || exu_rdata1 !== 32'd0) $display("FAIL mid_exu: mode %h rdata1 %h want 0 0", exu_mode, exu_rdata1); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_gid = 1'b1;
        seen = 0;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            seen |= rsp_valid;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL mid_ghost: got rsp_valid %b want 0", seen); else n_pass++;
        issue(1, 1, '{s1: 32'd1, s2: 32'd1, imm: 32'd0, mode: 11'd0}, '{s1: 32'd2, s2: 32'd2, imm: 32'd0, mode: 11'd0}, 0, 0);
        n_chk++; if (o_timeout !== 1'b0 || o_gid !== 1'b0 || o_data !== 32'd2) $display("FAIL mid_first_gnt: gid %b data %h want 0 2", o_gid, o_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_unsupported();
        test_compare();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
